dmem_arbiter: RTL and testbench

//  Shares one dmem instance (async read, sync byte-enabled write) between two requesters:

---
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single dmem (async read, sync byte-enabled write).
// Port 0 has priority; a saturating starvation counter and an optional RMW lock steer grants.
module dmem_arbiter #(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 14,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                p0_req_valid,
  output logic                p0_req_ready,
  input  logic [AWIDTH-1:0]   p0_req_addr,
  input  logic [DWIDTH/8-1:0] p0_req_wbe,
  input  logic [DWIDTH-1:0]   p0_req_wdata,
  input  logic                p0_req_lock,
  output logic                p0_resp_valid,
  output logic [DWIDTH-1:0]   p0_resp_rdata,
  input  logic                p1_req_valid,
  output logic                p1_req_ready,
  input  logic [AWIDTH-1:0]   p1_req_addr,
  input  logic [DWIDTH/8-1:0] p1_req_wbe,
  input  logic [DWIDTH-1:0]   p1_req_wdata,
  input  logic                p1_req_lock,
  output logic                p1_resp_valid,
  output logic [DWIDTH-1:0]   p1_resp_rdata,
  output logic [DWIDTH/8-1:0] mem_wbe,
  output logic [AWIDTH-1:0]   mem_addr,
  output logic [DWIDTH-1:0]   mem_dataw,
  input  logic [DWIDTH-1:0]   mem_datar
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  localparam logic [1:0] LOCK_NONE = 2'd0;
  localparam logic [1:0] LOCK_P0   = 2'd1;
  localparam logic [1:0] LOCK_P1   = 2'd2;

  logic [1:0]        r_lock_owner;
  logic [CW-1:0]     r_starve_cnt;
  logic              r_p0_resp_valid;
  logic              r_p1_resp_valid;
  logic [DWIDTH-1:0] r_p0_resp_rdata;
  logic [DWIDTH-1:0] r_p1_resp_rdata;

  logic              w_lock0;
  logic              w_lock1;
  logic              w_grant0;
  logic              w_grant1;
  logic [1:0]        w_lock_nxt;
  logic [CW-1:0]     w_starve_nxt;

  // A lock only binds while its owner keeps requesting; an idle owner releases it at once.
  assign w_lock0 = (r_lock_owner == LOCK_P0) && p0_req_valid;
  assign w_lock1 = (r_lock_owner == LOCK_P1) && p1_req_valid;

  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!rst_n) begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
    end else if (w_lock0) begin
      w_grant0 = 1'b1;
    end else if (w_lock1) begin
      w_grant1 = 1'b1;
    end else if (p0_req_valid && p1_req_valid) begin
      if (r_starve_cnt == LIMIT) w_grant1 = 1'b1;
      else                       w_grant0 = 1'b1;
    end else begin
      w_grant0 = p0_req_valid;
      w_grant1 = p1_req_valid;
    end
  end

  assign p0_req_ready = w_grant0;
  assign p1_req_ready = w_grant1;

  always_comb begin
    mem_addr  = w_grant1 ? p1_req_addr  : p0_req_addr;
    mem_dataw = w_grant1 ? p1_req_wdata : p0_req_wdata;
    if (w_grant1)      mem_wbe = p1_req_wbe;
    else if (w_grant0) mem_wbe = p0_req_wbe;
    else               mem_wbe = '0;
  end

  // Any accept either re-takes the lock or releases whatever lock could still be live.
  always_comb begin
    w_lock_nxt = r_lock_owner;
    if (((r_lock_owner == LOCK_P0) && !p0_req_valid) ||
        ((r_lock_owner == LOCK_P1) && !p1_req_valid))
      w_lock_nxt = LOCK_NONE;
    if (w_grant0) w_lock_nxt = p0_req_lock ? LOCK_P0 : LOCK_NONE;
    if (w_grant1) w_lock_nxt = p1_req_lock ? LOCK_P1 : LOCK_NONE;
  end

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (!p1_req_valid || w_grant1)  w_starve_nxt = '0;
    else if (r_starve_cnt < LIMIT)  w_starve_nxt = r_starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_owner    <= LOCK_NONE;
      r_starve_cnt    <= '0;
      r_p0_resp_valid <= 1'b0;
      r_p1_resp_valid <= 1'b0;
      r_p0_resp_rdata <= '0;
      r_p1_resp_rdata <= '0;
    end else begin
      r_lock_owner    <= w_lock_nxt;
      r_starve_cnt    <= w_starve_nxt;
      r_p0_resp_valid <= w_grant0;
      r_p1_resp_valid <= w_grant1;
      if (w_grant0) r_p0_resp_rdata <= mem_datar;
      if (w_grant1) r_p1_resp_rdata <= mem_datar;
    end
  end

  assign p0_resp_valid = r_p0_resp_valid;
  assign p1_resp_valid = r_p1_resp_valid;
  assign p0_resp_rdata = r_p0_resp_rdata;
  assign p1_resp_rdata = r_p1_resp_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural dmem (async read, byte-enabled sync write).
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 14;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          p0_req_valid, p0_req_ready, p0_req_lock, p0_resp_valid;
  logic [AW-1:0] p0_req_addr;
  logic [BW-1:0] p0_req_wbe;
  logic [DW-1:0] p0_req_wdata, p0_resp_rdata;
  logic          p1_req_valid, p1_req_ready, p1_req_lock, p1_resp_valid;
  logic [AW-1:0] p1_req_addr;
  logic [BW-1:0] p1_req_wbe;
  logic [DW-1:0] p1_req_wdata, p1_resp_rdata;
  logic [BW-1:0] mem_wbe;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dataw, mem_datar;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_addr(p0_req_addr),
    .p0_req_wbe(p0_req_wbe), .p0_req_wdata(p0_req_wdata), .p0_req_lock(p0_req_lock),
    .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_addr(p1_req_addr),
    .p1_req_wbe(p1_req_wbe), .p1_req_wdata(p1_req_wdata), .p1_req_lock(p1_req_lock),
    .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata),
    .mem_wbe(mem_wbe), .mem_addr(mem_addr), .mem_dataw(mem_dataw), .mem_datar(mem_datar)
  );

  assign mem_datar = mem[mem_addr];

  always @(posedge clk) begin
    for (int b = 0; b < BW; b++)
      if (mem_wbe[b]) mem[mem_addr][b*8 +: 8] <= mem_dataw[b*8 +: 8];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    p0_req_valid = 1'b0; p0_req_wbe = '0; p0_req_lock = 1'b0;
    p1_req_valid = 1'b0; p1_req_wbe = '0; p1_req_lock = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    rst_n = 1'b0;
    idle_all();
    p0_req_addr = '0; p0_req_wdata = '0; p1_req_addr = '0; p1_req_wdata = '0;

    // reset: a pending write request must not reach dmem
    p0_req_valid = 1'b1; p0_req_wbe = 4'hF; p0_req_addr = 14'd5; p0_req_wdata = 32'hFFFF_FFFF;
    #2;
    chk("rst_ready0", p0_req_ready, 1'b0);
    chk("rst_wbe", mem_wbe, 4'h0);
    chk("rst_rvalid0", p0_resp_valid, 1'b0);
    chk("rst_rdata0", p0_resp_rdata, 32'h0);
    cyc();
    chk("rst_mem5", mem[5], 32'h0);
    idle_all();
    rst_n = 1'b1;
    cyc();

    // idle drive: address follows p0, no write enable
    p0_req_addr = 14'd7; p0_req_wbe = 4'hF; #1;
    chk("idle_addr", mem_addr, 14'd7);
    chk("idle_wbe", mem_wbe, 4'h0);
    p0_req_wbe = '0;

    // p0 partial write then read-after-write
    p0_req_valid = 1'b1; p0_req_addr = 14'd5; p0_req_wbe = 4'b0011; p0_req_wdata = 32'hAABB_CCDD;
    #1;
    chk("w5_ready0", p0_req_ready, 1'b1);
    chk("w5_ready1", p1_req_ready, 1'b0);
    chk("w5_wbe", mem_wbe, 4'b0011);
    cyc();
    chk("w5_rvalid", p0_resp_valid, 1'b1);
    chk("w5_rdata", p0_resp_rdata, 32'h0);
    chk("w5_p1valid", p1_resp_valid, 1'b0);
    p0_req_wbe = '0;
    cyc();
    chk("r5_rvalid", p0_resp_valid, 1'b1);
    chk("r5_rdata", p0_resp_rdata, 32'h0000_CCDD);
    idle_all();
    cyc();
    chk("r5_pulse_end", p0_resp_valid, 1'b0);
    chk("r5_hold", p0_resp_rdata, 32'h0000_CCDD);

    // contention: 4 p0 grants then 1 p1 grant, repeating
    p0_req_valid = 1'b1; p0_req_addr = 14'd1;
    p1_req_valid = 1'b1; p1_req_addr = 14'd2;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("arb_r0_%0d", i), p0_req_ready, (i % 5) != 4);
      chk($sformatf("arb_r1_%0d", i), p1_req_ready, (i % 5) == 4);
      cyc();
    end
    idle_all();

    // seed addr 9
    p0_req_valid = 1'b1; p0_req_addr = 14'd9; p0_req_wbe = 4'hF; p0_req_wdata = 32'h1111_2222;
    cyc();
    p0_req_wbe = '0; p0_req_addr = 14'd3;

    // lock: p1 wins by starvation, locks, then writes while p0 keeps asking
    p1_req_valid = 1'b1; p1_req_addr = 14'd9; p1_req_lock = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    #1;
    chk("lk_rd_ready1", p1_req_ready, 1'b1);
    chk("lk_rd_ready0", p0_req_ready, 1'b0);
    cyc();
    chk("lk_rd_rdata", p1_resp_rdata, 32'h1111_2222);
    p1_req_wbe = 4'hF; p1_req_wdata = 32'h3333_4444; p1_req_lock = 1'b0;
    #1;
    chk("lk_wr_ready0", p0_req_ready, 1'b0);
    chk("lk_wr_ready1", p1_req_ready, 1'b1);
    cyc();
    chk("lk_wr_rvalid", p1_resp_valid, 1'b1);
    chk("lk_wr_rdata", p1_resp_rdata, 32'h1111_2222);
    p1_req_valid = 1'b0; p1_req_wbe = '0; p0_req_addr = 14'd9;
    #1;
    chk("lk_after_ready0", p0_req_ready, 1'b1);
    cyc();
    chk("lk_after_rdata", p0_resp_rdata, 32'h3333_4444);
    idle_all();
    cyc();

    // lock released when owner drops valid
    p1_req_valid = 1'b1; p1_req_addr = 14'd2; p1_req_lock = 1'b1;
    cyc();
    p0_req_valid = 1'b1; p0_req_addr = 14'd9;
    #1;
    chk("drop_locked_r1", p1_req_ready, 1'b1);
    chk("drop_locked_r0", p0_req_ready, 1'b0);
    cyc();
    p1_req_valid = 1'b0;
    #1;
    chk("drop_r0", p0_req_ready, 1'b1);
    cyc();
    p1_req_valid = 1'b1; p1_req_lock = 1'b0;
    #1;
    chk("drop_cleared_r0", p0_req_ready, 1'b1);
    chk("drop_cleared_r1", p1_req_ready, 1'b0);
    idle_all();
    cyc();
    cyc();

    // reset while a response pulse is outstanding
    p0_req_valid = 1'b1; p0_req_addr = 14'd20; p0_req_wbe = 4'hF; p0_req_wdata = 32'hCAFE_F00D;
    cyc();
    chk("rp_pre_rvalid", p0_resp_valid, 1'b1);
    p0_req_wdata = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    #1;
    chk("rp_rvalid", p0_resp_valid, 1'b0);
    chk("rp_rdata", p0_resp_rdata, 32'h0);
    chk("rp_wbe", mem_wbe, 4'h0);
    chk("rp_ready0", p0_req_ready, 1'b0);
    cyc();
    chk("rp_rvalid_hold", p0_resp_valid, 1'b0);
    rst_n = 1'b1;
    p0_req_wbe = '0;
    #1;
    chk("rp_rel_ready0", p0_req_ready, 1'b1);
    cyc();
    chk("rp_rel_rdata", p0_resp_rdata, 32'hCAFE_F00D);
    idle_all();
    cyc();

    // p1-only write stream over addr 0..7
    for (int i = 0; i < 8; i++) begin
      p1_req_valid = 1'b1; p1_req_wbe = 4'hF;
      p1_req_addr = AW'(i); p1_req_wdata = 32'h0000_0100 + DW'(i);
      #1;
      chk($sformatf("st_ready1_%0d", i), p1_req_ready, 1'b1);
      cyc();
      chk($sformatf("st_rvalid_%0d", i), p1_resp_valid, 1'b1);
      chk($sformatf("st_rdata_%0d", i), p1_resp_rdata, (i == 5) ? 32'h0000_CCDD : 32'h0);
      chk($sformatf("st_starve_%0d", i), dut.r_starve_cnt, 3'd0);
    end
    idle_all();
    cyc();
    chk("st_end_rvalid", p1_resp_valid, 1'b0);
    p0_req_valid = 1'b1; p0_req_addr = 14'd6;
    cyc();
    chk("st_readback6", p0_resp_rdata, 32'h0000_0106);
    idle_all();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
